i2s_tx_serializer: RTL and testbench

- Transmit end of the audio path. Accepts parallel stereo samples from the digital core (VALID, left/right 16-bit) and serializes them as an I2S stream to the codec DAC.
- Generates BCLK and LRCLK, double-buffers one stereo sample, and flags underrun and overrun.
- Sits between the effects core outputs and the codec pins.

---
 rtl/i2s_tx_serializer_pkg.sv | 19 +
 rtl/i2s_tx_serializer_if.sv | 15 +
 rtl/i2s_tx_serializer_clk_gen.sv | 50 +++++
 rtl/i2s_tx_serializer.sv | 105 ++++++++++
 tb/tb_i2s_tx_serializer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_tx_serializer_pkg.sv
// Shared types, default parameters and slot-bit helper for the I2S transmit path.
package i2s_pkg;

  localparam int DATA_W   = 16;
  localparam int SLOT_W   = 32;
  localparam int BCLK_DIV = 4;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Maps a position inside a channel slot to the sample bit driven there.
  // Position 0 is the one-BCLK I2S delay; positions past the sample are padding (-1).
  function automatic int slot_bit_idx(input int slot_pos, input int data_w);
    if (slot_pos >= 1 && slot_pos <= data_w) begin
      return data_w - slot_pos;
    end
    return -1;
  endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Parallel stereo sample bus from the effects core into the I2S transmitter.
interface i2s_tx_serializer_if #(
  parameter int DATA_W = i2s_pkg::DATA_W
) ();

  // VALID is a single-cycle strobe with no back-pressure: left_in/right_in are
  // captured in any cycle VALID is 1; the receiver never stalls the source.
  logic              VALID;
  logic [DATA_W-1:0] left_in;
  logic [DATA_W-1:0] right_in;

  modport master (output VALID, output left_in, output right_in);
  modport slave  (input  VALID, input  left_in, input  right_in);

endinterface

// File: rtl/i2s_tx_serializer_clk_gen.sv
// BCLK divider plus LRCLK and frame bit counter; flags each BCLK falling event.
module i2s_clk_gen import i2s_pkg::*; #(
  parameter int BCLK_DIV = i2s_pkg::BCLK_DIV,
  parameter int SLOT_W   = i2s_pkg::SLOT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          falling_evt,
  output logic [$clog2(2*SLOT_W)-1:0]   bit_cnt
);

  localparam int CNT_W = $clog2(2*SLOT_W);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt_q;
  logic             div_tc;

  assign div_tc      = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign falling_evt = div_tc && bclk;
  // bit_cnt is the frame position that takes effect at this falling event.
  assign bit_cnt     = (cnt_q == CNT_W'(2*SLOT_W - 1)) ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b1;
      cnt_q   <= CNT_W'(2*SLOT_W - 1);
    end else begin
      if (div_tc) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (falling_evt) begin
        cnt_q <= bit_cnt;
        if (bit_cnt == '0) begin
          lrclk <= 1'b0;
        end else if (bit_cnt == CNT_W'(SLOT_W)) begin
          lrclk <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: one-deep stereo holding buffer, frame shifters, underrun/overrun flags.
// Optional I2S_TX_MUTE_EN adds a mute input that zeroes the pair loaded at a frame boundary.
module i2s_tx_serializer import i2s_pkg::*; #(
  parameter int DATA_W   = i2s_pkg::DATA_W,
  parameter int BCLK_DIV = i2s_pkg::BCLK_DIV,
  parameter int SLOT_W   = i2s_pkg::SLOT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  i2s_tx_serializer_if.slave  smp,
`ifdef I2S_TX_MUTE_EN
  input  logic                mute,
`endif
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SDout,
  output logic                frame_start,
  output logic                underrun,
  output logic                overrun
);

  localparam int CNT_W = $clog2(2*SLOT_W);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              falling_evt;
  logic [CNT_W-1:0]  bit_cnt;
  logic              load;
  logic [DATA_W-1:0] hold_l, hold_r, shift_l, shift_r;
  logic [DATA_W-1:0] ld_l, ld_r;
  logic              hold_full;
  logic              sd_nxt;
  logic              in_left;
  int                cnt_i, pos, idx;

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_W   (SLOT_W)
  ) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .bclk        (BCLK),
    .lrclk       (LRCLK),
    .falling_evt (falling_evt),
    .bit_cnt     (bit_cnt)
  );

  assign load = falling_evt && (bit_cnt == '0);

`ifdef I2S_TX_MUTE_EN
  assign ld_l = mute ? '0 : hold_l;
  assign ld_r = mute ? '0 : hold_r;
`else
  assign ld_l = hold_l;
  assign ld_r = hold_r;
`endif

  always_comb begin
    cnt_i   = int'(bit_cnt);
    in_left = (cnt_i < SLOT_W);
    pos     = in_left ? cnt_i : cnt_i - SLOT_W;
    idx     = slot_bit_idx(pos, DATA_W);
    sd_nxt  = 1'b0;
    if (idx >= 0) begin
      sd_nxt = in_left ? shift_l[IDX_W'(idx)] : shift_r[IDX_W'(idx)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_l      <= '0;
      hold_r      <= '0;
      hold_full   <= 1'b0;
      shift_l     <= '0;
      shift_r     <= '0;
      SDout       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      // On underrun the holding regs are untouched, so the last pair repeats.
      if (load) begin
        shift_l     <= ld_l;
        shift_r     <= ld_r;
        frame_start <= 1'b1;
        underrun    <= ~hold_full;
      end
      // A write coinciding with a load refills the emptied buffer: no overrun.
      if (smp.VALID) begin
        hold_l    <= smp.left_in;
        hold_r    <= smp.right_in;
        hold_full <= 1'b1;
        overrun   <= hold_full && !load;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (falling_evt) begin
        SDout <= sd_nxt;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: frame-level model vs. stream decoded from the pins.
module tb_i2s_tx_serializer;
  import i2s_pkg::*;

  localparam int DW = 16;
  localparam int SW = 32;
  localparam int BD = 2;
  localparam int FP = 2 * SW * 2 * BD;

  logic clk;
  logic rst_n;
  logic bclk, lrclk, sdout, frame_start, underrun, overrun;
`ifdef I2S_TX_MUTE_EN
  logic mute;
`endif

  int checks;
  int errors;
  int n;
  logic [2*DW:0] exp_q[$];
  int            ovr_q[$];
  logic [DW-1:0] m_l, m_r;
  bit            m_full;

  i2s_tx_serializer_if #(.DATA_W(DW)) smp ();

  i2s_tx_serializer #(
    .DATA_W   (DW),
    .BCLK_DIV (BD),
    .SLOT_W   (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .smp         (smp),
`ifdef I2S_TX_MUTE_EN
    .mute        (mute),
`endif
    .BCLK        (bclk),
    .LRCLK       (lrclk),
    .SDout       (sdout),
    .frame_start (frame_start),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // A load happens at the first falling event after reset and every frame after.
  function automatic bit is_load_edge(input int edge_n);
    return (edge_n >= 2*BD - 1) && (((edge_n - (2*BD - 1)) % FP) == 0);
  endfunction

  // reference model: frame-level view of the holding buffer, evaluated per clk edge
  initial begin
    bit ld;
    bit mv;
    n = 0;
    m_full = 1'b0;
    m_l = '0;
    m_r = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0;
        m_full = 1'b0;
        m_l = '0;
        m_r = '0;
        exp_q.delete();
        ovr_q.delete();
      end else begin
        ld = is_load_edge(n);
        mv = 1'b0;
`ifdef I2S_TX_MUTE_EN
        mv = mute;
`endif
        if (ld) begin
          exp_q.push_back({~m_full, mv ? {DW{1'b0}} : m_l, mv ? {DW{1'b0}} : m_r});
          m_full = 1'b0;
        end
        if (smp.VALID) begin
          if (m_full) ovr_q.push_back(n);
          m_l = smp.left_in;
          m_r = smp.right_in;
          m_full = 1'b1;
        end
        n++;
      end
    end
  end

  // monitor: decodes the serial stream on BCLK rising edges and pops the scoreboard
  initial begin
    int cyc, pos, p, last_start, last_rise;
    bit bclk_p, lr_last, pad_ok, fs_seen, u_obs;
    logic [DW-1:0] l_w, r_w;
    logic [2*DW:0] e;
    cyc = 0; pos = -1; last_start = -1; last_rise = -1;
    bclk_p = 0; lr_last = 1; pad_ok = 1; fs_seen = 0; u_obs = 0;
    l_w = '0; r_w = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pos = -1; bclk_p = 0; lr_last = 1; fs_seen = 0;
        last_start = -1; last_rise = -1;
        continue;
      end
      if (underrun && !frame_start) chk("underrun_without_frame_start", 1, 0);
      if (frame_start) begin
        fs_seen = 1;
        u_obs = underrun;
      end
      if (overrun) begin
        if (ovr_q.size() == 0) chk("overrun_unexpected", 1, 0);
        else chk("overrun_edge", n - 1, ovr_q.pop_front());
      end
      if (bclk && !bclk_p) begin
        if (!lrclk && lr_last) begin
          if (last_start >= 0) chk("lrclk_period", cyc - last_start, FP);
          last_start = cyc;
          pos = 0; pad_ok = 1; l_w = '0; r_w = '0;
        end
        if (pos >= 0) begin
          p = pos % SW;
          if (lrclk !== (pos >= SW)) pad_ok = 0;
          if (p >= 1 && p <= DW) begin
            if (pos < SW) l_w = {l_w[DW-2:0], sdout};
            else r_w = {r_w[DW-2:0], sdout};
          end else if (sdout !== 1'b0) begin
            pad_ok = 0;
          end
          if (pos == 2*SW - 1) begin
            chk("bclk_period", cyc - last_rise, 2*BD);
            chk("frame_start_seen", fs_seen, 1);
            if (exp_q.size() == 0) begin
              chk("frame_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("frame_underrun", u_obs, e[2*DW]);
              chk("frame_left", l_w, e[2*DW-1:DW]);
              chk("frame_right", r_w, e[DW-1:0]);
            end
            chk("frame_pad_lrclk", pad_ok, 1);
            fs_seen = 0;
            pos = -1;
          end else begin
            pos++;
          end
        end
        lr_last = lrclk;
        last_rise = cyc;
      end
      bclk_p = bclk;
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    smp.VALID = 1'b1;
    smp.left_in = l;
    smp.right_in = r;
    @(negedge clk);
    smp.VALID = 1'b0;
  endtask

  // Returns at the negedge just before a load edge.
  task automatic wait_load();
    for (int i = 0; i < 2*FP; i++) begin
      if (is_load_edge(n)) return;
      @(negedge clk);
    end
    chk("wait_load_timeout", 1, 0);
  endtask

  task automatic after_load(input int gap);
    wait_load();
    @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    sample_t rl, rr;
    int k;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    smp.VALID = 1'b0;
    smp.left_in = '0;
    smp.right_in = '0;
`ifdef I2S_TX_MUTE_EN
    mute = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 1);
    chk("rst_sdout", sdout, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // idle frames: zeros with underrun
    repeat (2*FP) @(negedge clk);

    // known pattern ahead of a boundary
    after_load(30);
    send(16'hA5C3, 16'h8001);

    // two writes in one frame: overrun, newest wins
    after_load(10);
    send(16'h1111, 16'h1111);
    repeat (20) @(negedge clk);
    send(16'h2222, 16'h2222);

    // write exactly in the load cycle
    after_load(10);
    send(16'h0001, 16'h0001);
    wait_load();
    send(16'h7FFF, 16'h7FFF);
    repeat (2*FP) @(negedge clk);

    // randomized traffic, including occasional load-cycle writes
    for (int f = 0; f < 8; f++) begin
      after_load(0);
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(1, 100)) @(negedge clk);
        rl = sample_t'($urandom_range(0, 65535));
        rr = sample_t'($urandom_range(0, 65535));
        send(rl, rr);
      end
      if ($urandom_range(0, 3) == 0) begin
        wait_load();
        rl = sample_t'($urandom_range(0, 65535));
        rr = sample_t'($urandom_range(0, 65535));
        send(rl, rr);
      end
    end

`ifdef I2S_TX_MUTE_EN
    after_load(10);
    send(16'hFFFF, 16'hFFFF);
    wait_load();
    mute = 1'b1;
    @(negedge clk);
    mute = 1'b0;
    repeat (2*FP) @(negedge clk);
`endif

    // asynchronous reset in the middle of a slot
    after_load(40);
    for (int i = 0; i < 8; i++) begin
      if (bclk) break;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bclk", bclk, 0);
    chk("async_rst_lrclk", lrclk, 1);
    chk("async_rst_sdout", sdout, 0);
    chk("async_rst_frame_start", frame_start, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 2*BD; i++) begin
      @(negedge clk);
      chk("post_rst_frame_start", frame_start, (i == 2*BD));
      if (i == 2*BD) chk("post_rst_underrun", underrun, 1);
    end
    after_load(20);
    rl = sample_t'($urandom_range(0, 65535));
    send(rl, ~rl);
    repeat (FP) @(negedge clk);

    // drain the scoreboard at a frame boundary
    begin
      bit drained;
      drained = 0;
      for (int i = 0; i < 2*FP; i++) begin
        if (exp_q.size() == 0) begin
          drained = 1;
          break;
        end
        @(negedge clk);
      end
      chk("drain_timeout", drained, 1);
    end
    chk("overrun_missing", ovr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
